// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions: opcodes, flag bit positions
// and the sequencer state encoding.
package alu_ctrl_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_SLT  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_NAND = 3'd5;
    localparam logic [2:0] OP_NOR  = 3'd6;
    localparam logic [2:0] OP_OR   = 3'd7;

    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or
// above ptr, wrapping from NREQ-1 back to 0.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            any_grant
);

    int pos;

    // Scan NREQ positions starting at ptr; keep the first hit.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        pos       = 0;
        for (int i = 0; i < NREQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (!any_grant && req[pos]) begin
                any_grant = 1'b1;
                grant_idx = IW'(pos);
            end
        end
        if (any_grant) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_sequencer.sv
// Time-shares one combinational ALU among NREQ requesters:
// round-robin accept, hold operands ALU_LAT cycles, return result.
module alu_share_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int WIDTH   = 32,
    parameter int OPW     = 3,
    parameter int ALU_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*OPW-1:0]   req_op,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [OPW-1:0]        alu_op,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic [3:0]            alu_flags,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_result,
    output logic [3:0]            rsp_flags,
    output logic                  busy
);

    localparam int         IW       = $clog2(NREQ);
    localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);

    seq_state_e       state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [3:0]       lat_cnt_q, lat_cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;

    logic [NREQ-1:0]  grant;
    logic [IW-1:0]    grant_idx;
    logic             any_grant;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Next-state, datapath loads and handshake outputs.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        lat_cnt_d    = lat_cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        req_ready    = '0;
        rsp_valid    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_grant) begin
                    req_ready = grant;
                    alu_a_d   = req_a[int'(grant_idx)*WIDTH +: WIDTH];
                    alu_b_d   = req_b[int'(grant_idx)*WIDTH +: WIDTH];
                    alu_op_d  = req_op[int'(grant_idx)*OPW +: OPW];
                    owner_d   = grant_idx;
                    lat_cnt_d = LAT_INIT;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (lat_cnt_q == 4'd0) begin
                    rsp_result_d = alu_result;
                    rsp_flags_d  = alu_flags;
                    state_d      = ST_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    if (owner_q == IW'(NREQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = owner_q + 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            lat_cnt_q    <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            lat_cnt_q    <= lat_cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
